mf_sequencer: RTL and testbench
===============================

Name: mf_sequencer

Overview:
- Top-level controller for the matched-filter chain.
- On start it:
  - enables the coefficient loader and waits for its set flag;
  - gates DATA_LENGTH complex input samples from an upstream source into the FIR core via a valid/ready handshake;
  - injects COEFF_LENGTH-1 zero samples to flush the filter tail, then reports done.
- Sits between the sample source, the coefficient setup block and the complex FIR filter.

Parameters:
- COEFF_LENGTH, 10000, number of complex coefficients streamed by the coefficient loader.
- DATA_LENGTH, 20000, number of complex input samples per run.
- DATA_WIDTH, 16, signed width of each real/imag sample.
- TIMEOUT_MARGIN, 64, extra cycles beyond COEFF_LENGTH+2 allowed for coeffSetFlag before error.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle run request; ignored unless in IDLE or DONE.
- coeffEnable  output  1  enable to coefficient loader.
- coeffSetFlag  input  1  loader finished flag (sticky high).
- inValid  input  1  upstream sample valid.
- inReady  output  1  upstream sample accepted when inValid&&inReady.
- inDataRe  input  DATA_WIDTH  signed upstream real sample.
- inDataIm  input  DATA_WIDTH  signed upstream imag sample.
- filterEnable  output  1  FIR advance strobe, one per sample fed.
- filterDataRe  output  DATA_WIDTH  signed sample to FIR.
- filterDataIm  output  DATA_WIDTH  signed sample to FIR.
- busy  output  1  high in any state other than IDLE/DONE/ERROR.
- done  output  1  high in DONE.
- error  output  1  high in ERROR (coefficient timeout).
- sampleCount  output  20  samples (data+flush) fed in current run.

Behaviour:
- Reset (reset==0 at clock edge):
  - state=IDLE; all outputs 0; coeffLoaded=0; counters=0.
  - Applies mid-run from any state; coeffLoaded is also cleared.
- coeffLoaded: internal sticky bit, set when coeffSetFlag seen. The loader cannot re-arm, so later runs skip LOAD.
- States:
  - IDLE: outputs 0. On start: go to LOAD if !coeffLoaded, else STREAM; sampleCount<=0.
  - LOAD: coeffEnable=1, timeout counter increments each cycle.
    - coeffSetFlag==1: coeffEnable<=0, coeffLoaded<=1, go to STREAM.
    - Counter reaches COEFF_LENGTH+2+TIMEOUT_MARGIN: go to ERROR.
  - STREAM: inReady=1 combinationally with state.
    - Accepted beat: filterData<=inData, filterEnable<=1 for exactly that next cycle, sampleCount+1.
    - No beat: filterEnable<=0 and filterData hold.
    - When the DATA_LENGTH-th beat is accepted: inReady drops the following cycle, go to FLUSH.
  - FLUSH: inReady=0. Each cycle filterData<=0, filterEnable<=1, sampleCount+1, for COEFF_LENGTH-1 cycles.
    - Then go to DONE; filterEnable<=0.
    - COEFF_LENGTH==1 means FLUSH lasts 0 cycles (go straight to DONE).
  - DONE: done=1, sampleCount holds DATA_LENGTH+COEFF_LENGTH-1. start: done<=0, go to STREAM (coeffLoaded set).
  - ERROR: error=1, coeffEnable=0; exits only by reset; start ignored.
  - Undefined encoding: go to IDLE, outputs cleared.
- Latency:
  - Accepted input beat appears on filterData one cycle later with filterEnable.
  - LOAD→STREAM transition is one cycle after coeffSetFlag rises.
- start while busy is ignored. start in the same cycle as reset: reset wins.
- coeffSetFlag high already on entry to LOAD: exit after one cycle.
- sampleCount is 20 bits; the parameter sum DATA_LENGTH+COEFF_LENGTH-1 must be < 2^20 (elaboration check).

Decomposition:
- Shared package mf_pkg holds:
  - state encodings (IDLE, LOAD, STREAM, FLUSH, DONE, ERROR; 3-bit);
  - the count width constant 20;
  - the DATA_WIDTH default.
- One sub-module is natural: mf_beat_counter (parameterised terminal-count counter with clear/increment/tc). It is instanced for the timeout, data and flush counts.

Test Plan (COEFF_LENGTH=4, DATA_LENGTH=6, TIMEOUT_MARGIN=8):
- Reset low 2 cycles then start; loader model raises coeffSetFlag 5 cycles later → coeffEnable high exactly until flag seen, then STREAM next cycle, busy=1.
- Feed inputs (1,-1)…(6,-6) with inValid always high → six filterEnable pulses with matching data one cycle after acceptance, then 3 zero samples, done=1, sampleCount=9.
- inValid toggled 1010… in STREAM → filterEnable pulses only for accepted beats, data order preserved, total still 6 data + 3 flush.
- coeffSetFlag never asserted → error=1 after 14 cycles in LOAD, coeffEnable=0, start ignored until reset.
- Second start from DONE → LOAD skipped (coeffEnable stays 0), STREAM entered next cycle, sampleCount restarts at 0.
- reset pulsed low mid-STREAM after 3 beats → all outputs 0 next cycle, state IDLE, next start re-enters LOAD.

Source files
------------

// File: rtl/mf_pkg.sv
// mf_pkg: shared types and constants for the matched-filter sequencer.
// State encodings, sample-count width and the default sample width.
package mf_pkg;

  localparam int CNT_W      = 20;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } mf_state_e;

  function automatic logic st_busy(input mf_state_e s);
    return (s == ST_LOAD) || (s == ST_STREAM) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/mf_beat_counter.sv
// mf_beat_counter: up-counter that flags its TERMINAL-th step.
// last is high while the next increment completes the count.
module mf_beat_counter #(
  parameter int TERMINAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [W-1:0] LAST_V = W'(TERMINAL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == LAST_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mf_sequencer.sv
// mf_sequencer: run controller for the matched-filter chain.
// Loads coefficients once, gates samples into the FIR, then flushes.
module mf_sequencer
  import mf_pkg::*;
#(
  parameter int COEFF_LENGTH   = 10000,
  parameter int DATA_LENGTH    = 20000,
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int TIMEOUT_MARGIN = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         coeffEnable,
  input  logic                         coeffSetFlag,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic signed [DATA_WIDTH-1:0] inDataRe,
  input  logic signed [DATA_WIDTH-1:0] inDataIm,
  output logic                         filterEnable,
  output logic signed [DATA_WIDTH-1:0] filterDataRe,
  output logic signed [DATA_WIDTH-1:0] filterDataIm,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [CNT_W-1:0]             sampleCount
);

  localparam int TOTAL    = DATA_LENGTH + COEFF_LENGTH - 1;
  localparam int TO_LIMIT = COEFF_LENGTH + 2 + TIMEOUT_MARGIN;
  localparam int FL_LEN   = (COEFF_LENGTH > 1) ? COEFF_LENGTH - 1 : 1;

  if (TOTAL >= (1 << CNT_W) || COEFF_LENGTH < 1 ||
      DATA_LENGTH < 1) begin : g_bad_cfg
    $error("mf_sequencer: lengths do not fit sampleCount");
  end

  mf_state_e state_q, state_d;

  logic                         loaded_q, loaded_d;
  logic                         fen_q, fen_d;
  logic signed [DATA_WIDTH-1:0] fre_q, fre_d;
  logic signed [DATA_WIDTH-1:0] fim_q, fim_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         coeff_en_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         error_q;

  logic to_last;
  logic dat_last;
  logic fl_last;
  logic beat;

  assign beat = (state_q == ST_STREAM) && inValid;

  mf_beat_counter #(.TERMINAL(TO_LIMIT)) u_timeout (
    .clk  (clock),
    .rst_n(reset),
    .clr  (state_q != ST_LOAD),
    .inc  (state_q == ST_LOAD),
    .last (to_last)
  );

  mf_beat_counter #(.TERMINAL(DATA_LENGTH)) u_data (
    .clk  (clock),
    .rst_n(reset),
    .clr  (state_q != ST_STREAM),
    .inc  (beat),
    .last (dat_last)
  );

  mf_beat_counter #(.TERMINAL(FL_LEN)) u_flush (
    .clk  (clock),
    .rst_n(reset),
    .clr  (state_q != ST_FLUSH),
    .inc  (state_q == ST_FLUSH),
    .last (fl_last)
  );

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    fen_d    = 1'b0;
    fre_d    = fre_q;
    fim_d    = fim_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        fre_d = '0;
        fim_d = '0;
        if (start) begin
          state_d = loaded_q ? ST_STREAM : ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (coeffSetFlag) begin
          loaded_d = 1'b1;
          state_d  = ST_STREAM;
        end else if (to_last) begin
          state_d = ST_ERROR;
        end
      end
      ST_STREAM: begin
        if (beat) begin
          fen_d = 1'b1;
          fre_d = inDataRe;
          fim_d = inDataIm;
          cnt_d = cnt_q + 1'b1;
          if (dat_last) begin
            state_d = (COEFF_LENGTH > 1) ? ST_FLUSH : ST_DONE;
          end
        end
      end
      ST_FLUSH: begin
        // zeros push the last data sample through the filter taps
        fen_d = 1'b1;
        fre_d = '0;
        fim_d = '0;
        cnt_d = cnt_q + 1'b1;
        if (fl_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
        end
      end
      ST_ERROR: begin
        fre_d = '0;
        fim_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        fre_d   = '0;
        fim_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      loaded_q   <= 1'b0;
      fen_q      <= 1'b0;
      fre_q      <= '0;
      fim_q      <= '0;
      cnt_q      <= '0;
      coeff_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      loaded_q   <= loaded_d;
      fen_q      <= fen_d;
      fre_q      <= fre_d;
      fim_q      <= fim_d;
      cnt_q      <= cnt_d;
      coeff_en_q <= (state_d == ST_LOAD);
      busy_q     <= st_busy(state_d);
      done_q     <= (state_d == ST_DONE);
      error_q    <= (state_d == ST_ERROR);
    end
  end

  assign inReady      = (state_q == ST_STREAM);
  assign coeffEnable  = coeff_en_q;
  assign filterEnable = fen_q;
  assign filterDataRe = fre_q;
  assign filterDataIm = fim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign sampleCount  = cnt_q;

endmodule

// File: tb/tb_mf_sequencer.sv
// tb_mf_sequencer: directed runs of the sequencer against a
// phase-level reference model plus literal end-of-run checks.
module tb_mf_sequencer;

  localparam int C     = 4;
  localparam int D     = 6;
  localparam int TM    = 8;
  localparam int W     = 16;
  localparam int LMAX  = C + 2 + TM;
  localparam int TOTAL = D + C - 1;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic coeffSetFlag;
  logic inValid;
  logic signed [W-1:0] inDataRe;
  logic signed [W-1:0] inDataIm;
  logic coeffEnable;
  logic inReady;
  logic filterEnable;
  logic signed [W-1:0] filterDataRe;
  logic signed [W-1:0] filterDataIm;
  logic busy;
  logic done;
  logic error;
  logic [19:0] sampleCount;

  always #5 clock = ~clock;

  mf_sequencer #(
    .COEFF_LENGTH  (C),
    .DATA_LENGTH   (D),
    .DATA_WIDTH    (W),
    .TIMEOUT_MARGIN(TM)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .coeffEnable (coeffEnable),
    .coeffSetFlag(coeffSetFlag),
    .inValid     (inValid),
    .inReady     (inReady),
    .inDataRe    (inDataRe),
    .inDataIm    (inDataIm),
    .filterEnable(filterEnable),
    .filterDataRe(filterDataRe),
    .filterDataIm(filterDataIm),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .sampleCount (sampleCount)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  int ce;
  int kk;

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // reference model: run phase, sample tally, last fed sample
  typedef enum {P_IDLE, P_LOAD, P_STREAM, P_FLUSH, P_DONE, P_ERR} phase_e;
  phase_e ph = P_IDLE;
  bit m_loaded = 0;
  bit m_fen = 0;
  int m_cnt = 0;
  int m_lc = 0;
  int m_re = 0;
  int m_im = 0;

  always @(posedge clock) begin
    if (!reset) begin
      ph = P_IDLE; m_loaded = 0; m_fen = 0;
      m_cnt = 0; m_lc = 0; m_re = 0; m_im = 0;
    end else begin
      m_fen = 0;
      case (ph)
        P_IDLE: begin
          m_re = 0; m_im = 0;
          if (start) begin
            m_cnt = 0; m_lc = 0;
            ph = m_loaded ? P_STREAM : P_LOAD;
          end
        end
        P_LOAD: begin
          m_lc++;
          if (coeffSetFlag) begin
            m_loaded = 1; ph = P_STREAM;
          end else if (m_lc == LMAX) begin
            ph = P_ERR;
          end
        end
        P_STREAM: if (inValid) begin
          m_fen = 1; m_re = inDataRe; m_im = inDataIm;
          m_cnt++;
          if (m_cnt == D) ph = (C > 1) ? P_FLUSH : P_DONE;
        end
        P_FLUSH: begin
          m_fen = 1; m_re = 0; m_im = 0; m_cnt++;
          if (m_cnt == TOTAL) ph = P_DONE;
        end
        P_DONE: if (start) begin
          m_cnt = 0; ph = P_STREAM;
        end
        P_ERR: begin
          m_re = 0; m_im = 0;
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("coeffEnable", coeffEnable, ph == P_LOAD);
      chk("inReady", inReady, ph == P_STREAM);
      chk("busy", busy,
          ph == P_LOAD || ph == P_STREAM || ph == P_FLUSH);
      chk("done", done, ph == P_DONE);
      chk("error", error, ph == P_ERR);
      chk("filterEnable", filterEnable, m_fen);
      chk("filterDataRe", filterDataRe, m_re);
      chk("filterDataIm", filterDataIm, m_im);
      chk("sampleCount", sampleCount, m_cnt);
    end
  end

  int log_re[$];
  int log_im[$];

  always @(negedge clock) begin
    if (filterEnable === 1'b1) begin
      log_re.push_back(int'(filterDataRe));
      log_im.push_back(int'(filterDataIm));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic feed(input bit toggle, input int nb);
    int idx = 0;
    int k = 0;
    while (idx < nb && k < 100) begin
      inValid  = toggle ? (k % 2 == 0) : 1'b1;
      inDataRe = W'(idx + 1);
      inDataIm = W'(-(idx + 1));
      if (inValid && inReady) idx++;
      k++;
      tick();
    end
    inValid = 1'b0;
    chk("feed_beats", idx, nb);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("done_reached", done, 1);
    chk("final_count", sampleCount, 9);
    tick();
  endtask

  task automatic chk_log();
    chk("log_len", log_re.size(), 9);
    for (int i = 0; i < 9 && i < log_re.size(); i++) begin
      chk("log_re", log_re[i], (i < 6) ? i + 1 : 0);
      chk("log_im", log_im[i], (i < 6) ? -(i + 1) : 0);
    end
    log_re.delete();
    log_im.delete();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; coeffSetFlag = 1'b0;
    inValid = 1'b0; inDataRe = '0; inDataIm = '0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_count", sampleCount, 0);
    chk("rst_fen", filterEnable, 0);
    reset = 1'b1;

    // run 1: load, loader flag after 5 cycles, continuous data
    start = 1'b1;
    tick();
    start = 1'b0;
    ce = 0;
    for (int k = 0; k < 5; k++) begin
      if (coeffEnable === 1'b1) ce++;
      if (k == 4) coeffSetFlag = 1'b1;
      tick();
    end
    chk("ce_cycles", ce, 5);
    chk("stream_busy", busy, 1);
    chk("stream_ready", inReady, 1);
    chk("stream_ce", coeffEnable, 0);
    feed(1'b0, D);
    wait_done();
    chk_log();

    // run 2: restart from DONE, load skipped, gappy valid
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r2_ce", coeffEnable, 0);
    chk("r2_ready", inReady, 1);
    chk("r2_count", sampleCount, 0);
    feed(1'b1, D);
    wait_done();
    chk_log();

    // run 3: reset mid-stream after three beats
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(1'b0, 3);
    reset = 1'b0;
    coeffSetFlag = 1'b0;
    tick();
    chk("mr_busy", busy, 0);
    chk("mr_ready", inReady, 0);
    chk("mr_fen", filterEnable, 0);
    chk("mr_count", sampleCount, 0);
    chk("mr_re", filterDataRe, 0);
    reset = 1'b1;
    log_re.delete();
    log_im.delete();

    // run 4: reload, loader never answers -> timeout
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r4_ce", coeffEnable, 1);
    ce = 0;
    kk = 0;
    while (error !== 1'b1 && kk < 40) begin
      if (coeffEnable === 1'b1) ce++;
      kk++;
      tick();
    end
    chk("load_cycles", ce, 14);
    chk("err_flag", error, 1);
    chk("err_ce", coeffEnable, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("err_sticky", error, 1);
    chk("err_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("err_cleared", error, 0);
    reset = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
